// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM state encodings
// shared by alu_core and alu_arbiter.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU shared by all requesters.
// Ports: op_i, a_i, b_i in; result_o, flags_o ({N,V,C,Z}) out.
// Flag logic exists only with ALU_ARBITER_FLAGS_EN defined;
// otherwise flags_o is tied to zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o
);

    localparam int SHW = $clog2(WIDTH);
`ifdef ALU_ARBITER_FLAGS_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [SHW-1:0]   shamt;
    logic [SW-1:0]    sum;

    // sub is a + ~b + 1, sharing the adder with add
    assign is_sub = (op_i == OP_SUB);
    assign b_eff  = is_sub ? ~b_i : b_i;
    assign sum    = SW'(a_i) + SW'(b_eff) + SW'(is_sub);
    assign shamt  = b_i[SHW-1:0];

    always_comb begin
        result_o = '0;
        unique case (op_i)
            OP_ADD,
            OP_SUB: result_o = sum[WIDTH-1:0];
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_SLT: result_o = {{(WIDTH-1){1'b0}},
                                $signed(a_i) < $signed(b_i)};
            OP_SLL: result_o = a_i << shamt;
            OP_SRL: result_o = a_i >> shamt;
            OP_SRA: result_o = $signed(a_i) >>> shamt;
            default: result_o = '0;
        endcase
    end

`ifdef ALU_ARBITER_FLAGS_EN
    logic arith;

    assign arith = is_sub | (op_i == OP_ADD);

    // overflow: operands of equal sign producing a sum of the other sign
    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_Z] = (result_o == '0);
        flags_o[FLAG_N] = result_o[WIDTH-1];
        flags_o[FLAG_C] = arith & sum[WIDTH];
        flags_o[FLAG_V] = arith
                        & (a_i[WIDTH-1] == b_eff[WIDTH-1])
                        & (sum[WIDTH-1] != a_i[WIDTH-1]);
    end
`else
    assign flags_o = 4'b0000;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one alu_core among NREQ
// requesters; IDLE grants, EXEC registers the ALU, RESP holds result.
// Ports: req_valid/req_ready/req_op/req_a/req_b per requester slice;
// rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_flags response channel.
// Define ALU_ARBITER_FLAGS_EN to build the flag logic and registers.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic [3:0]            rsp_flags
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;

    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;

    logic             grant_vld;
    logic [IDW-1:0]   grant_idx;
    logic [NREQ-1:0]  ready_c;

    alu_core #(
        .WIDTH    (WIDTH)
    ) u_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    // first valid requester after last_q, wrapping at NREQ
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_vld &&
                req_valid[IDW'((int'(last_q) + k) % NREQ)]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'((int'(last_q) + k) % NREQ);
            end
        end
    end

`ifdef ALU_ARBITER_FLAGS_EN
    logic [3:0] rsp_flags_q, rsp_flags_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
`ifdef ALU_ARBITER_FLAGS_EN
        rsp_flags_d  = rsp_flags_q;
`endif
        ready_c      = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    ready_c[grant_idx] = 1'b1;
                    op_d    = req_op[int'(grant_idx)*3 +: 3];
                    a_d     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
                    b_d     = req_b[int'(grant_idx)*WIDTH +: WIDTH];
                    id_d    = grant_idx;
                    last_d  = grant_idx;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_valid_d  = 1'b1;
                rsp_id_d     = id_q;
                rsp_result_d = core_result;
`ifdef ALU_ARBITER_FLAGS_EN
                rsp_flags_d  = core_flags;
`endif
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // no grant is visible while reset is held
    assign req_ready = rst_n ? ready_c : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_q       <= IDW'(NREQ - 1);
            id_q         <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

`ifdef ALU_ARBITER_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_flags_q <= '0;
        end else begin
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign rsp_flags = rsp_flags_q;
`else
    assign rsp_flags = core_flags;
`endif

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized bench for alu_arbiter,
// checked every cycle against a behavioural transaction model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;
`ifdef ALU_ARBITER_FLAGS_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [3*N-1:0]  req_op;
    logic [W*N-1:0]  req_a;
    logic [W*N-1:0]  req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [W-1:0]    rsp_result;
    logic [3:0]      rsp_flags;

    alu_arbiter #(
        .WIDTH      (W),
        .NREQ       (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  res;
        logic [3:0]    fl;
    } exp_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // reference ALU from plain 64-bit arithmetic
    function automatic logic [35:0] ref_alu(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint ua, ub, sa, sb, full;
        logic [31:0] r;
        logic c, v;
        int sh;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        c = 1'b0;
        v = 1'b0;
        full = 0;
        r = '0;
        case (op)
            3'd0: begin
                full = ua + ub;
                r = full[31:0];
                c = full[32];
                v = (sa + sb) != longint'($signed(r));
            end
            3'd1: begin
                full = ua + (ub ^ 64'hFFFF_FFFF) + 1;
                r = full[31:0];
                c = full[32];
                v = (sa - sb) != longint'($signed(r));
            end
            3'd2: r = a | b;
            3'd3: r = a ^ b;
            3'd4: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd5: r = a << sh;
            3'd6: r = a >> sh;
            default: begin
                full = sa >>> sh;
                r = full[31:0];
            end
        endcase
        return {r, FE ? {r[31], v, c, (r == 32'd0)} : 4'b0000};
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic exp_t mk_exp(input int g);
        exp_t e;
        e.id = IW'(g);
        {e.res, e.fl} = ref_alu(req_op[g*3 +: 3], req_a[g*W +: W],
                                req_b[g*W +: W]);
        return e;
    endfunction

    // model: at most one op in flight; response due from the
    // second cycle after acceptance until the response handshake
    logic m_pending = 1'b0;
    int   m_age     = 0;
    int   m_last    = N - 1;
    exp_t m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending <= 1'b0;
            m_age     <= 0;
            m_last    <= N - 1;
        end else if (m_pending) begin
            if (m_age >= 1 && rsp_ready) m_pending <= 1'b0;
            else m_age <= m_age + 1;
        end else if (pick(req_valid, m_last) >= 0) begin
            m_pending <= 1'b1;
            m_age     <= 0;
            m_last    <= pick(req_valid, m_last);
            m_exp     <= mk_exp(pick(req_valid, m_last));
        end
    end

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        if (rst_n === 1'b1 && !m_pending) begin
            g = pick(req_valid, m_last);
            if (g >= 0) r[g] = 1'b1;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        chk("req_ready", req_ready, exp_ready());
        chk("rsp_valid", rsp_valid,
            (rst_n === 1'b1) && m_pending && (m_age >= 1));
        if (rst_n === 1'b1 && m_pending && m_age >= 1) begin
            chk("rsp_id", rsp_id, m_exp.id);
            chk("rsp_result", rsp_result, m_exp.res);
            chk("rsp_flags", rsp_flags, m_exp.fl);
        end
    end

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[i*3 +: 3] = op;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 20);
        chk("accept", req_ready[i], 1'b1);
    endtask

    // one lone request with rsp_ready high; checks 2-cycle latency
    task automatic do_op(input int i, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] f,
                         output logic [IW-1:0] id);
        set_req(i, op, a, b);
        req_valid    = '0;
        req_valid[i] = 1'b1;
        wait_ready(i);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        @(negedge clk);
        chk("lat_c1", rsp_valid, 1'b0);
        @(negedge clk);
        chk("lat_c2", rsp_valid, 1'b1);
        r  = rsp_result;
        f  = rsp_flags;
        id = rsp_id;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0]   r, cr;
        logic [3:0]    f, cf;
        logic [IW-1:0] id, ci;
        logic [N-1:0]  hs;
        int n, cyc, nacc, nrsp, ai;
        int acc_cyc[8];
        int rsp_ids[6];

        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_id", rsp_id, 2'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_flags", rsp_flags, 4'b0000);
        @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(0, OP_ADD, 32'hFFFF_FFFF, 32'd1, r, f, id);
        chk("add_res", r, 32'h0000_0000);
        chk("add_flags", f, FE ? 4'b0011 : 4'b0000);
        chk("add_id", id, 2'd0);

        do_op(2, OP_SUB, 32'h8000_0000, 32'd1, r, f, id);
        chk("sub_res", r, 32'h7FFF_FFFF);
        chk("sub_flags", f, FE ? 4'b0110 : 4'b0000);
        chk("sub_id", id, 2'd2);

        do_op(3, OP_SRA, 32'h8000_0000, 32'h3F, r, f, id);
        chk("sra_res", r, 32'hFFFF_FFFF);
        chk("sra_flags", f, FE ? 4'b1000 : 4'b0000);
        chk("sra_id", id, 2'd3);

        do_op(1, OP_SLT, 32'hFFFF_FFFF, 32'd1, r, f, id);
        chk("slt_res", r, 32'h0000_0001);
        chk("slt_flags", f, 4'b0000);

        do_op(0, OP_SRL, 32'h8000_0000, 32'd4, r, f, id);
        chk("srl_res", r, 32'h0800_0000);
        chk("srl_flags", f, 4'b0000);

        // backpressure with other requesters waiting
        rsp_ready = 1'b0;
        set_req(1, OP_ADD, 32'd5, 32'd7);
        req_valid = 4'b0010;
        wait_ready(1);
        @(posedge clk);
        #1;
        set_req(0, OP_XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
        set_req(3, OP_OR, 32'h1234_0000, 32'h0000_5678);
        req_valid = 4'b1001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 10);
        chk("bp_valid", rsp_valid, 1'b1);
        cr = rsp_result;
        ci = rsp_id;
        cf = rsp_flags;
        chk("bp_res", cr, 32'd12);
        chk("bp_id", ci, 2'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_v", rsp_valid, 1'b1);
            chk("bp_hold_r", rsp_result, cr);
            chk("bp_hold_id", rsp_id, ci);
            chk("bp_hold_f", rsp_flags, cf);
            chk("bp_rdy", req_ready, 4'b0000);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("bp_hs_v", rsp_valid, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_done_v", rsp_valid, 1'b0);

        // reset while the op is in EXEC
        set_req(1, OP_XOR, 32'hFFFF_0000, 32'h00FF_FF00);
        req_valid = 4'b0010;
        wait_ready(1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rexec_v", rsp_valid, 1'b0);
        chk("rexec_rdy", req_ready, 4'b0000);
        repeat (2) begin
            @(negedge clk);
            chk("rexec_hold_v", rsp_valid, 1'b0);
            chk("rexec_hold_rdy", req_ready, 4'b0000);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rexec_no_rsp", rsp_valid, 1'b0);
        end

        // round robin with all requesters continuously valid
        for (int i = 0; i < N; i++)
            set_req(i, 3'($urandom_range(0, 7)), rnd_word(), rnd_word());
        for (int i = 0; i < 8; i++) acc_cyc[i] = -1;
        for (int i = 0; i < 6; i++) rsp_ids[i] = -1;
        @(posedge clk);
        #1 req_valid = 4'b1111;
        cyc = 0;
        nacc = 0;
        nrsp = 0;
        while (nrsp < 6 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            ai = -1;
            for (int i = 0; i < N; i++) if (req_ready[i]) ai = i;
            if (ai >= 0 && nacc < 8) begin
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            if (rsp_valid) begin
                rsp_ids[nrsp] = int'(rsp_id);
                nrsp++;
            end
            @(posedge clk);
            #1;
            if (ai >= 0)
                set_req(ai, 3'($urandom_range(0, 7)), rnd_word(),
                        rnd_word());
        end
        chk("rr_count", nrsp, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("rr_id%0d", i), rsp_ids[i], i % 4);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_gap%0d", i), acc_cyc[i+1] - acc_cyc[i], 3);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !hs[i]) begin
                    if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    set_req(i, 3'($urandom_range(0, 7)), rnd_word(),
                            rnd_word());
                end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares one combinational ALU among NREQ requesters using round-robin arbitration.
- Accepts one operation at a time over a valid/ready request channel, executes it in a registered stage, and returns result, flags and requester ID over a valid/ready response channel.
- Sits between the issuing engines and the shared `alu_core` datapath.

## Interface
- `WIDTH`, 32: operand/result width; power of 2, ≥ 8.
- `NREQ`, 4: number of requesters, 2..16.
- `IDW`, $clog2(NREQ): response ID width (derived).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: per-requester request valid.
- `req_ready` output NREQ: per-requester accept; at most one bit high.
- `req_op` input 3*NREQ: opcode, slice i belongs to requester i.
- `req_a` input WIDTH*NREQ: operand A slices.
- `req_b` input WIDTH*NREQ: operand B slices.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response consumer ready.
- `rsp_id` output IDW: index of the requester served.
- `rsp_result` output WIDTH: ALU result.
- `rsp_flags` output 4: {negative, overflow, carry, zero}.

## Operation
Opcodes:
- 000 add; 001 sub (a + ~b + 1).
- 010 or; 011 xor.
- 100 slt: signed a < b gives 1, else 0.
- 101 sll; 110 srl; 111 sra.
- Shift amount is `b[$clog2(WIDTH)-1:0]`; the upper bits of b are ignored.

Flags:
- zero = (result == 0).
- negative = result[WIDTH-1].
- carry = carry-out of bit WIDTH-1 for add/sub (sub: 1 means no borrow); 0 for other ops.
- overflow = signed overflow for add/sub; 0 for other ops.

FSM states IDLE, EXEC, RESP:
- IDLE:
  - Grant the first valid requester searching from `last_grant+1` modulo NREQ.
  - `req_ready[g]` = 1 combinationally for the grantee only.
  - On handshake, latch op, a, b and g; set `last_grant` = g; go to EXEC.
  - With no valid requests, stay in IDLE and hold `req_ready` = 0.
- EXEC: register the `alu_core` outputs into the rsp_* registers; go to RESP.
- RESP:
  - Hold `rsp_valid` = 1 with stable outputs until `rsp_ready`.
  - On handshake go to IDLE.
  - `req_ready` = 0 throughout RESP.

Rules:
- Requesters hold op, a and b stable while valid and not yet accepted; dropping valid before acceptance is permitted.
- Grant is recomputed every IDLE cycle; there is no grant lock before the handshake.

Reset (asynchronous, any state):
- State → IDLE.
- `last_grant` = NREQ-1, so requester 0 wins first.
- `rsp_valid` = 0; `rsp_id`, `rsp_result` and `rsp_flags` = 0.
- `req_ready` = 0.
- Any in-flight operation is discarded without a response.

## Timing
- Acceptance in cycle c0 gives EXEC in c1 and `rsp_valid` high from c2.
- Latency is 2 cycles from acceptance to first response-valid cycle.
- Throughput is one operation per 3 cycles when `rsp_ready` = 1. The next acceptance happens at earliest in the cycle after the response handshake.
- All outputs except `req_ready` are registered. `req_ready` depends combinationally on state, `req_valid` and `last_grant`.
- Fairness: any continuously valid requester is served within NREQ operations.

## Configuration
- `ALU_ARBITER_FLAGS_EN` defined:
  - Flags are computed and registered as specified.
- Undefined:
  - Flag logic and registers are not instantiated; `rsp_flags` is tied to 4'b0000.
  - Result, ID and timing are unchanged.

## Structure
- Package `alu_pkg` holds:
  - Opcode constants (OP_ADD … OP_SRA).
  - Flag bit indices (FLAG_Z = 0, FLAG_C = 1, FLAG_V = 2, FLAG_N = 3).
  - FSM state encodings.
- Sub-module `alu_core`: purely combinational; inputs op, a, b; outputs result and flags. It is instantiated once.
- Arbitration and FSM stay in `alu_arbiter`.

## Test plan
- Reset, then idle:
  - Assert `rst_n` = 0 mid-EXEC → `rsp_valid` = 0, `req_ready` = 0, and no response is ever produced for that operation.
  - After release, a request from req0 is granted first.
- Add wrap (req0, add, a = 0xFFFFFFFF, b = 1):
  - `rsp_valid` rises 2 cycles after acceptance.
  - result = 0x00000000, flags = {N0, V0, C1, Z1}, id = 0.
- Signed overflow (req2, sub, a = 0x80000000, b = 1):
  - result = 0x7FFFFFFF, flags = {N0, V1, C1, Z0}, id = 2.
- Round-robin (all 4 requesters valid continuously, `rsp_ready` = 1):
  - rsp_id order is 0, 1, 2, 3, 0, 1.
  - One acceptance every 3 cycles.
- Backpressure (`rsp_ready` = 0 for 5 cycles during RESP):
  - `rsp_*` outputs stay stable and `req_ready` stays 0.
  - Handshake completes in the cycle `rsp_ready` = 1.
- Shifts/slt:
  - sra a = 0x80000000, b = 0x3F → 0xFFFFFFFF, N = 1.
  - slt a = 0xFFFFFFFF, b = 1 → 0x00000001.
  - srl a = 0x80000000, b = 4 → 0x08000000.
